// File: rtl/noc_flit_injector.sv
// NoC flit injector: buffers local write/read requests in a small FIFO and serialises each one
// into a 4-flit packet (head, address, data, tail) toward the network interface.
module noc_flit_injector #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FLIT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [3:0]        req_dest,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_en,
  input  logic              ni_ready,
  output logic              busy,
  output logic [7:0]        pkt_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic        write;
    logic [3:0]  dest;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  typedef enum logic [2:0] {StIdle, StHead, StAddr, StData, StTail} state_e;

  req_t                        mem_q [FIFO_DEPTH];
  req_t                        mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]             count_q, count_d;
  state_e                      state_q, state_d;
  logic [FLIT_W-1:0]           flit_q, flit_d;
  logic [2:0][FLIT_W-1:0]      body_q, body_d;
  logic [7:0]                  pkt_cnt_q, pkt_cnt_d;

  logic              push, pop, empty, xfer;
  req_t              head_req;
  logic [15:0]       wdata_pkt, tail_mix;
  logic [FLIT_W-1:0] new_head;
  logic [2:0][FLIT_W-1:0] new_body;

  assign empty     = (count_q == '0);
  assign req_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign flit_en   = (state_q != StIdle);
  assign xfer      = flit_en && ni_ready;
  assign flit_out  = flit_q;
  assign busy      = (state_q != StIdle) || !empty;
  assign pkt_count = pkt_cnt_q;

  // Flits for the request at the FIFO head, ready to load on a pop edge.
  always_comb begin
    head_req    = mem_q[rd_ptr_q];
    wdata_pkt   = head_req.write ? head_req.wdata : 16'h0000;
    tail_mix    = head_req.addr ^ wdata_pkt;
    new_head    = {2'b01, head_req.write, head_req.dest, 9'b0};
    new_body[0] = head_req.addr;
    new_body[1] = wdata_pkt;
    new_body[2] = {2'b11, tail_mix[13:0]};
  end

  always_comb begin
    state_d   = state_q;
    flit_d    = flit_q;
    body_d    = body_q;
    pkt_cnt_d = pkt_cnt_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StHead;
          flit_d  = new_head;
          body_d  = new_body;
        end
      end
      StHead: begin
        if (xfer) begin
          state_d = StAddr;
          flit_d  = body_q[0];
        end
      end
      StAddr: begin
        if (xfer) begin
          state_d = StData;
          flit_d  = body_q[1];
        end
      end
      StData: begin
        if (xfer) begin
          state_d = StTail;
          flit_d  = body_q[2];
        end
      end
      StTail: begin
        if (xfer) begin
          pkt_cnt_d = pkt_cnt_q + 8'd1;
          // Chain straight into the next packet so the stream has no idle bubble.
          if (!empty) begin
            pop     = 1'b1;
            state_d = StHead;
            flit_d  = new_head;
            body_d  = new_body;
          end else begin
            state_d = StIdle;
            flit_d  = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        flit_d  = '0;
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{write: req_write, dest: req_dest, addr: req_addr, wdata: req_wdata};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      flit_q    <= '0;
      body_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      flit_q    <= flit_d;
      body_q    <= body_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
